// File: rtl/idli_alu_m.sv
// idli_alu_m: nibble-serial 16-bit ALU.
// Consumes one 4-bit nibble of operands B and C per cycle (LS nibble first),
// produces one result nibble per cycle for the register file A write port,
// and reports {N, Z, C, V} flags one cycle after the last nibble.

module idli_alu_m (
    input  logic       i_alu_gck,
    input  logic       i_alu_rst_n,
    input  logic       i_alu_start,
    input  logic [2:0] i_alu_op,
    input  logic       i_alu_nowr,
    input  logic [3:0] i_alu_b_data,
    input  logic [3:0] i_alu_c_data,
    output logic [3:0] o_alu_a_data,
    output logic       o_alu_a_vld,
    output logic       o_alu_busy,
    output logic [1:0] o_alu_nibble,
    output logic       o_alu_done,
    output logic [3:0] o_alu_flags
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_ANDN = 3'd5;
    localparam logic [2:0] OP_ADC  = 3'd6;
    localparam logic [2:0] OP_SBC  = 3'd7;

    // Flag bit positions within {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    logic       active_q;
    logic [1:0] cnt_q;
    logic [2:0] op_q;
    logic       nowr_q;
    logic       carry_q;
    logic       zacc_q;
    logic [3:0] flags_q;
    logic       done_q;

    logic [2:0] eff_op;
    logic       eff_nowr;
    logic [1:0] eff_nib;
    logic       busy;
    logic       is_arith;
    logic       is_sub;
    logic       cin;
    logic [3:0] c_x;
    logic [4:0] sum5;
    logic [3:0] res;
    logic       zacc_nxt;
    logic       last_nib;
    logic [3:0] flags_nxt;

    // Per-nibble datapath: pick the effective op, form carry-in, compute result and next flags
    always_comb begin
        eff_op    = i_alu_start ? i_alu_op   : op_q;
        eff_nowr  = i_alu_start ? i_alu_nowr : nowr_q;
        eff_nib   = i_alu_start ? 2'd0       : cnt_q;
        busy      = i_alu_start | active_q;

        is_arith  = (eff_op == OP_ADD) || (eff_op == OP_SUB) ||
                    (eff_op == OP_ADC) || (eff_op == OP_SBC);
        is_sub    = (eff_op == OP_SUB) || (eff_op == OP_SBC);

        // flags_q is loaded on the same edge that raises done, so a start in
        // the done cycle already sees the freshly computed carry here.
        cin = carry_q;
        if (eff_nib == 2'd0) begin
            case (eff_op)
                OP_SUB:         cin = 1'b1;
                OP_ADC, OP_SBC: cin = flags_q[FLAG_C];
                default:        cin = 1'b0;
            endcase
        end

        c_x  = is_sub ? ~i_alu_c_data : i_alu_c_data;
        sum5 = {1'b0, i_alu_b_data} + {1'b0, c_x} + {4'd0, cin};

        case (eff_op)
            OP_AND:  res = i_alu_b_data & i_alu_c_data;
            OP_OR:   res = i_alu_b_data | i_alu_c_data;
            OP_XOR:  res = i_alu_b_data ^ i_alu_c_data;
            OP_ANDN: res = i_alu_b_data & ~i_alu_c_data;
            default: res = sum5[3:0];
        endcase

        zacc_nxt = ((eff_nib == 2'd0) ? 1'b1 : zacc_q) & (res == 4'd0);
        last_nib = busy && (eff_nib == 2'd3);

        flags_nxt         = 4'd0;
        flags_nxt[FLAG_N] = res[3];
        flags_nxt[FLAG_Z] = zacc_nxt;
        flags_nxt[FLAG_C] = is_arith & sum5[4];
        flags_nxt[FLAG_V] = is_arith & (i_alu_b_data[3] == c_x[3]) &
                            (res[3] != i_alu_b_data[3]);
    end

    // Sequencing, carry/zero accumulation and flag capture
    always_ff @(posedge i_alu_gck) begin
        if (!i_alu_rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= 2'd0;
            op_q     <= OP_ADD;
            nowr_q   <= 1'b0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b1;
            flags_q  <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_nib;

            if (i_alu_start) begin
                active_q <= 1'b1;
                cnt_q    <= 2'd1;
                op_q     <= i_alu_op;
                nowr_q   <= i_alu_nowr;
            end else if (active_q) begin
                if (cnt_q == 2'd3) begin
                    active_q <= 1'b0;
                    cnt_q    <= 2'd0;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
            end

            if (busy) begin
                zacc_q <= zacc_nxt;
                if (is_arith) begin
                    carry_q <= sum5[4];
                end
            end

            if (last_nib) begin
                flags_q <= flags_nxt;
            end
        end
    end

    assign o_alu_a_data = busy ? res : 4'd0;
    assign o_alu_a_vld  = busy & ~eff_nowr;
    assign o_alu_busy   = busy;
    assign o_alu_nibble = eff_nib;
    assign o_alu_done   = done_q;
    assign o_alu_flags  = flags_q;

    // A new start may not land on the final nibble of a running operation
    a_no_start_at_last_nib : assert property (
        @(posedge i_alu_gck) disable iff (!i_alu_rst_n)
        !(i_alu_start && active_q && (cnt_q == 2'd3))
    );

endmodule

// File: tb/tb_idli_alu_m.sv
// tb_idli_alu_m: directed, table-driven bench for the nibble-serial ALU.
// Inputs change on the falling edge and outputs are checked 2 ns later,
// well away from the rising edge.

module tb_idli_alu_m;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic       nowr;
    logic [3:0] b_data;
    logic [3:0] c_data;
    logic [3:0] a_data;
    logic       a_vld;
    logic       busy;
    logic [1:0] nibble;
    logic       done;
    logic [3:0] flags;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] AND_ = 3'd2;
    localparam logic [2:0] OR_  = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4;
    localparam logic [2:0] ANDN = 3'd5;
    localparam logic [2:0] ADC  = 3'd6;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        nowr;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[10];

    idli_alu_m dut (
        .i_alu_gck    (clk),
        .i_alu_rst_n  (rst_n),
        .i_alu_start  (start),
        .i_alu_op     (op),
        .i_alu_nowr   (nowr),
        .i_alu_b_data (b_data),
        .i_alu_c_data (c_data),
        .o_alu_a_data (a_data),
        .o_alu_a_vld  (a_vld),
        .o_alu_busy   (busy),
        .o_alu_nibble (nibble),
        .o_alu_done   (done),
        .o_alu_flags  (flags)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_stimulus(input logic s, input logic [2:0] o, input logic w,
                                  input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        start  = s;
        op     = o;
        nowr   = w;
        b_data = b;
        c_data = c;
        #2;
    endtask

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Four nibble cycles of one operation, starting on nibble 0
    task automatic run_op(input string name, input logic [2:0] o, input logic w,
                          input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] exp_res);
        for (int n = 0; n < 4; n++) begin
            apply_stimulus(n == 0, o, w, b[n*4 +: 4], c[n*4 +: 4]);
            check_output($sformatf("%s n%0d data", name, n), 16'(a_data), 16'(exp_res[n*4 +: 4]));
            check_output($sformatf("%s n%0d vld", name, n), 16'(a_vld), 16'(!w));
            check_output($sformatf("%s n%0d busy", name, n), 16'(busy), 16'd1);
            check_output($sformatf("%s n%0d idx", name, n), 16'(nibble), 16'(n));
            check_output($sformatf("%s n%0d done", name, n), 16'(done), 16'd0);
        end
    endtask

    // Idle cycle after nibble 3: done pulse and new flags expected
    task automatic check_done_cycle(input string name, input logic [3:0] exp_flags);
        apply_stimulus(1'b0, ADD, 1'b0, 4'd0, 4'd0);
        check_output({name, " done"}, 16'(done), 16'd1);
        check_output({name, " flags"}, 16'(flags), 16'(exp_flags));
        check_output({name, " idle busy"}, 16'(busy), 16'd0);
        check_output({name, " idle vld"}, 16'(a_vld), 16'd0);
    endtask

    initial begin
        // flags are {N, Z, C, V}
        vecs[0] = '{"add_00ff",  ADD,  1'b0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000};
        vecs[1] = '{"sub_eq",    SUB,  1'b0, 16'h1234, 16'h1234, 16'h0000, 4'b0110};
        vecs[2] = '{"sub_neg",   SUB,  1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000};
        vecs[3] = '{"add_ovf",   ADD,  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
        vecs[4] = '{"and",       AND_, 1'b0, 16'hF0A5, 16'h3C3C, 16'h3024, 4'b0000};
        vecs[5] = '{"or",        OR_,  1'b0, 16'hF0A5, 16'h3C3C, 16'hFCBD, 4'b1000};
        vecs[6] = '{"xor",       XOR_, 1'b0, 16'hF0A5, 16'h3C3C, 16'hCC99, 4'b1000};
        vecs[7] = '{"andn",      ANDN, 1'b0, 16'hF0A5, 16'h3C3C, 16'hC081, 4'b1000};
        vecs[8] = '{"xor_nowr",  XOR_, 1'b1, 16'h5A5A, 16'h5A5A, 16'h0000, 4'b0100};
        vecs[9] = '{"and_nowr",  AND_, 1'b1, 16'hF0A5, 16'h3C3C, 16'h3024, 4'b0000};

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = ADD;
        nowr   = 1'b0;
        b_data = 4'd0;
        c_data = 4'd0;

        // Reset state
        apply_stimulus(1'b0, ADD, 1'b0, 4'd0, 4'd0);
        apply_stimulus(1'b0, ADD, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, ADD, 1'b0, 4'd0, 4'd0);
        check_output("rst busy", 16'(busy), 16'd0);
        check_output("rst vld", 16'(a_vld), 16'd0);
        check_output("rst done", 16'(done), 16'd0);
        check_output("rst flags", 16'(flags), 16'd0);
        check_output("rst nibble", 16'(nibble), 16'd0);
        check_output("rst data", 16'(a_data), 16'd0);

        // Table-driven single operations
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].nowr, vecs[i].b, vecs[i].c, vecs[i].exp_res);
            check_done_cycle(vecs[i].name, vecs[i].exp_flags);
        end

        // Back-to-back: ADC starts in the done cycle of FFFF+1 and uses its carry
        run_op("add_wrap", ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000);
        apply_stimulus(1'b1, ADC, 1'b0, 4'd0, 4'd0);
        check_output("b2b done", 16'(done), 16'd1);
        check_output("b2b flags", 16'(flags), 16'h6);
        check_output("b2b n0 data", 16'(a_data), 16'd1);
        check_output("b2b n0 idx", 16'(nibble), 16'd0);
        check_output("b2b n0 busy", 16'(busy), 16'd1);
        for (int n = 1; n < 4; n++) begin
            apply_stimulus(1'b0, ADC, 1'b0, 4'd0, 4'd0);
            check_output($sformatf("b2b n%0d data", n), 16'(a_data), 16'd0);
            check_output($sformatf("b2b n%0d idx", n), 16'(nibble), 16'(n));
        end
        check_done_cycle("adc", 4'b0000);

        // Abort: ADD at t0, SUB restart at t2, single done at t6 with SUB flags
        apply_stimulus(1'b1, ADD, 1'b0, 4'h1, 4'h2);
        check_output("abort t0 done", 16'(done), 16'd0);
        apply_stimulus(1'b0, ADD, 1'b0, 4'h1, 4'h2);
        check_output("abort t1 idx", 16'(nibble), 16'd1);
        run_op("abort_sub", SUB, 1'b0, 16'h1234, 16'h1234, 16'h0000);
        check_done_cycle("abort_sub", 4'b0110);
        apply_stimulus(1'b0, ADD, 1'b0, 4'd0, 4'd0);
        check_output("abort t7 done", 16'(done), 16'd0);

        // Reset during nibble 1 of an overflowing ADD
        apply_stimulus(1'b1, ADD, 1'b0, 4'hF, 4'h1);
        check_output("mrst pre flags", 16'(flags), 16'h6);
        apply_stimulus(1'b0, ADD, 1'b0, 4'hF, 4'h0);
        rst_n = 1'b0;
        apply_stimulus(1'b0, ADD, 1'b0, 4'hF, 4'h0);
        rst_n = 1'b1;
        check_output("mrst busy", 16'(busy), 16'd0);
        check_output("mrst flags", 16'(flags), 16'd0);
        check_output("mrst vld", 16'(a_vld), 16'd0);
        check_output("mrst nibble", 16'(nibble), 16'd0);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("mrst done c%0d", k), 16'(done), 16'd0);
            apply_stimulus(1'b0, ADD, 1'b0, 4'd0, 4'd0);
        end
        check_output("mrst flags held", 16'(flags), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
